// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences IF/ID/EX/MEM/WB and drives datapath enables.
// Waits on a memory ready handshake with a bounded timeout and flags undecoded instructions.
module mc_ctrl #(
  parameter int ALUOP_W      = 3,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               EXTOp,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [2:0]         state,
  output logic               instr_done,
  output logic               illegal,
  output logic               mem_err
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [2:0] ALU_NOP  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] GPR_RD  = 2'b00;
  localparam logic [1:0] GPR_RT  = 2'b01;
  localparam logic [1:0] GPR_31  = 2'b10;
  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_PC   = 2'b10;

  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q;
  logic [2:0]       alu_sel;
  logic             pc_we;

  logic is_rtype, r_legal, is_j, is_jal, is_beq, is_addi, is_ori, is_lw, is_sw;
  logic legal;
  logic [2:0] dec_alu;
  logic dec_ext, dec_alusrc;

  assign is_rtype = (Op == OP_RTYPE);
  assign is_j     = (Op == OP_J);
  assign is_jal   = (Op == OP_JAL);
  assign is_beq   = (Op == OP_BEQ);
  assign is_addi  = (Op == OP_ADDI);
  assign is_ori   = (Op == OP_ORI);
  assign is_lw    = (Op == OP_LW);
  assign is_sw    = (Op == OP_SW);

  // R-type ALU function and legality come from Funct; I-type from Op alone.
  always_comb begin
    r_legal = 1'b1;
    case (Funct)
      F_ADD, F_ADDU: dec_alu = ALU_ADD;
      F_SUB, F_SUBU: dec_alu = ALU_SUB;
      F_AND:         dec_alu = ALU_AND;
      F_OR:          dec_alu = ALU_OR;
      F_SLT:         dec_alu = ALU_SLT;
      F_SLTU:        dec_alu = ALU_SLTU;
      default: begin
        dec_alu = ALU_NOP;
        r_legal = 1'b0;
      end
    endcase
    if (!is_rtype) begin
      if (is_addi || is_lw || is_sw) dec_alu = ALU_ADD;
      else if (is_ori)               dec_alu = ALU_OR;
      else if (is_beq)               dec_alu = ALU_SUB;
      else                           dec_alu = ALU_NOP;
    end
  end

  assign legal      = (is_rtype && r_legal) || is_j || is_jal || is_beq ||
                      is_addi || is_ori || is_lw || is_sw;
  assign dec_ext    = is_addi | is_lw | is_sw;
  assign dec_alusrc = is_lw | is_sw | is_addi | is_ori;

  always_comb begin
    state_d  = state_q;
    pc_we    = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    alu_sel  = ALU_NOP;
    NPCOp    = NPC_PLUS4;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    case (state_q)
      S_IF: begin
        IRWrite = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (!legal) begin
          illegal = 1'b1;
          pc_we   = 1'b1;
          state_d = S_IF;
        end else if (is_j || is_jal) begin
          pc_we   = 1'b1;
          NPCOp   = NPC_JUMP;
          state_d = S_IF;
          if (is_jal) begin
            RegWrite = 1'b1;
            GPRSel   = GPR_31;
            WDSel    = WD_PC;
          end
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_sel = dec_alu;
        ALUSrc  = dec_alusrc;
        EXTOp   = dec_ext;
        if (is_beq) begin
          pc_we   = 1'b1;
          NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
          state_d = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Address operands stay selected so memory sees a stable address while waiting.
        alu_sel  = ALU_ADD;
        ALUSrc   = 1'b1;
        EXTOp    = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if ((MEM_WAIT_MAX != 0) && (wcnt_q == WAIT_LAST)) begin
          mem_err = 1'b1;
          pc_we   = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        GPRSel   = (is_addi || is_ori || is_lw) ? GPR_RT : GPR_RD;
        WDSel    = is_lw ? WD_MEM : WD_ALU;
        pc_we    = 1'b1;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase

    if (rst) begin
      state_d  = S_IF;
      pc_we    = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      EXTOp    = 1'b0;
      ALUSrc   = 1'b0;
      alu_sel  = ALU_NOP;
      NPCOp    = NPC_PLUS4;
      GPRSel   = GPR_RD;
      WDSel    = WD_ALU;
      illegal  = 1'b0;
      mem_err  = 1'b0;
    end
  end

  always_comb begin
    ALUOp      = '0;
    ALUOp[2:0] = alu_sel;
  end

  assign PCWrite    = pc_we;
  assign instr_done = pc_we;
  assign state      = rst ? S_IF : state_q;

  // The wait counter only lives inside S_MEM; any exit leaves it at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_MEM && state_d != S_MEM) wcnt_q <= '0;
      else if (state_q == S_MEM && !mem_ready)  wcnt_q <= wcnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle vectors with hand-derived expected control outputs,
// queued when driven and compared mid-cycle.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BAD  = 6'h3F;

  logic       clk = 1'b0;
  logic       rst, Zero, mem_ready;
  logic [5:0] Op, Funct;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUSrc;
  logic [2:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [2:0] state;
  logic       instr_done, illegal, mem_err;

  always #5 clk = ~clk;

  mc_ctrl #(.ALUOP_W(3), .MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .state(state), .instr_done(instr_done),
    .illegal(illegal), .mem_err(mem_err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, rw, mr, mw, ext, asrc;
    logic [2:0] alu;
    logic [1:0] npc, gpr, wd;
    logic       ill, merr;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       ready;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic out_t eIF();
    out_t o = '0;
    o.st = 3'd0; o.irw = 1'b1;
    return o;
  endfunction

  function automatic out_t eID(input logic pcw, input logic [1:0] npc, input logic rw,
                               input logic [1:0] gpr, input logic [1:0] wd, input logic ill);
    out_t o = '0;
    o.st = 3'd1; o.pcw = pcw; o.npc = npc; o.rw = rw; o.gpr = gpr; o.wd = wd; o.ill = ill;
    return o;
  endfunction

  function automatic out_t eEX(input logic [2:0] alu, input logic asrc, input logic ext,
                               input logic pcw, input logic [1:0] npc);
    out_t o = '0;
    o.st = 3'd2; o.alu = alu; o.asrc = asrc; o.ext = ext; o.pcw = pcw; o.npc = npc;
    return o;
  endfunction

  function automatic out_t eMEM(input logic mr, input logic mw, input logic pcw,
                                input logic merr);
    out_t o = '0;
    o.st = 3'd3; o.alu = 3'd1; o.asrc = 1'b1; o.ext = 1'b1;
    o.mr = mr; o.mw = mw; o.pcw = pcw; o.merr = merr;
    return o;
  endfunction

  function automatic out_t eWB(input logic [1:0] gpr, input logic [1:0] wd);
    out_t o = '0;
    o.st = 3'd4; o.rw = 1'b1; o.pcw = 1'b1; o.gpr = gpr; o.wd = wd;
    return o;
  endfunction

  function automatic vec_t mkVec(input string name, input logic r, input logic [5:0] op,
                                 input logic [5:0] funct, input logic z, input logic rdy,
                                 input out_t e);
    vec_t v;
    v.name = name; v.rst = r; v.op = op; v.funct = funct;
    v.zero = z; v.ready = rdy; v.exp = e;
    return v;
  endfunction

  task automatic addVec(input string name, input logic r, input logic [5:0] op,
                        input logic [5:0] funct, input logic z, input logic rdy,
                        input out_t e);
    vecs.push_back(mkVec(name, r, op, funct, z, rdy, e));
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    Op        = v.op;
    Funct     = v.funct;
    Zero      = v.zero;
    mem_ready = v.ready;
    sb_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t v;
    out_t act;
    if (sb_q.size() == 0) begin
      nbad++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
      return;
    end
    v = sb_q.pop_front();
    act = {state, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUSrc,
           ALUOp, NPCOp, GPRSel, WDSel, illegal, mem_err};
    nvec++;
    if (act !== v.exp) begin
      nbad++;
      $display("[TB] FAIL %s: got %h expected %h", v.name, act, v.exp);
    end
    if (instr_done !== v.exp.pcw) begin
      nbad++;
      $display("[TB] FAIL %s_done: got instr_done=%b expected %b", v.name, instr_done, v.exp.pcw);
    end
  endtask

  task automatic runVec(input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] rf [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};
    logic [2:0] ra [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b0;

    addVec("rst0", 1, OP_R, 6'h20, 0, 0, '0);
    addVec("rst1", 1, OP_LW, 6'h00, 1, 1, '0);
    for (int k = 0; k < 8; k++) begin
      addVec($sformatf("r%02h_if", rf[k]), 0, OP_R, rf[k], 0, 0, eIF());
      addVec($sformatf("r%02h_id", rf[k]), 0, OP_R, rf[k], 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0));
      addVec($sformatf("r%02h_ex", rf[k]), 0, OP_R, rf[k], k[0], 0, eEX(ra[k], 0, 0, 0, 2'b00));
      addVec($sformatf("r%02h_wb", rf[k]), 0, OP_R, rf[k], 0, 0, eWB(2'b00, 2'b00));
    end
    addVec("beq1_if", 0, OP_BEQ, 6'h00, 1, 0, eIF());
    addVec("beq1_id", 0, OP_BEQ, 6'h00, 1, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0));
    addVec("beq1_ex", 0, OP_BEQ, 6'h00, 1, 0, eEX(3'd2, 0, 0, 1, 2'b01));
    addVec("beq0_if", 0, OP_BEQ, 6'h00, 0, 0, eIF());
    addVec("beq0_id", 0, OP_BEQ, 6'h00, 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0));
    addVec("beq0_ex", 0, OP_BEQ, 6'h00, 0, 0, eEX(3'd2, 0, 0, 1, 2'b00));
    addVec("ori_if", 0, OP_ORI, 6'h15, 0, 0, eIF());
    addVec("ori_id", 0, OP_ORI, 6'h15, 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0));
    addVec("ori_ex", 0, OP_ORI, 6'h15, 0, 0, eEX(3'd4, 1, 0, 0, 2'b00));
    addVec("ori_wb", 0, OP_ORI, 6'h15, 0, 0, eWB(2'b01, 2'b00));
    addVec("addi_if", 0, OP_ADDI, 6'h22, 0, 0, eIF());
    addVec("addi_id", 0, OP_ADDI, 6'h22, 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0));
    addVec("addi_ex", 0, OP_ADDI, 6'h22, 0, 0, eEX(3'd1, 1, 1, 0, 2'b00));
    addVec("addi_wb", 0, OP_ADDI, 6'h22, 0, 0, eWB(2'b01, 2'b00));
    addVec("lw3_if", 0, OP_LW, 6'h00, 0, 1, eIF());
    addVec("lw3_id", 0, OP_LW, 6'h00, 0, 1, eID(0, 2'b00, 0, 2'b00, 2'b00, 0));
    addVec("lw3_ex", 0, OP_LW, 6'h00, 0, 0, eEX(3'd1, 1, 1, 0, 2'b00));
    for (int k = 0; k < 3; k++)
      addVec($sformatf("lw3_wait%0d", k), 0, OP_LW, 6'h00, 0, 0, eMEM(1, 0, 0, 0));
    addVec("lw3_ready", 0, OP_LW, 6'h00, 0, 1, eMEM(1, 0, 0, 0));
    addVec("lw3_wb", 0, OP_LW, 6'h00, 0, 0, eWB(2'b01, 2'b01));
    addVec("bad_if", 0, OP_BAD, 6'h00, 0, 0, eIF());
    addVec("bad_id", 0, OP_BAD, 6'h00, 0, 0, eID(1, 2'b00, 0, 2'b00, 2'b00, 1));
    addVec("badfn_if", 0, OP_R, 6'h00, 0, 0, eIF());
    addVec("badfn_id", 0, OP_R, 6'h00, 0, 0, eID(1, 2'b00, 0, 2'b00, 2'b00, 1));
    addVec("jal_if", 0, OP_JAL, 6'h00, 0, 0, eIF());
    addVec("jal_id", 0, OP_JAL, 6'h00, 0, 0, eID(1, 2'b10, 1, 2'b10, 2'b10, 0));
    addVec("j_if", 0, OP_J, 6'h20, 0, 0, eIF());
    addVec("j_id", 0, OP_J, 6'h20, 0, 0, eID(1, 2'b10, 0, 2'b00, 2'b00, 0));

    foreach (vecs[i]) runVec(vecs[i]);

    // lw with ready in the very first MEM cycle
    runVec(mkVec("lw0_if", 0, OP_LW, 6'h00, 0, 0, eIF()));
    runVec(mkVec("lw0_id", 0, OP_LW, 6'h00, 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0)));
    runVec(mkVec("lw0_ex", 0, OP_LW, 6'h00, 0, 0, eEX(3'd1, 1, 1, 0, 2'b00)));
    runVec(mkVec("lw0_mem", 0, OP_LW, 6'h00, 0, 1, eMEM(1, 0, 0, 0)));
    runVec(mkVec("lw0_wb", 0, OP_LW, 6'h00, 0, 0, eWB(2'b01, 2'b01)));

    // sw retires directly from MEM once ready
    runVec(mkVec("sw1_if", 0, OP_SW, 6'h00, 0, 0, eIF()));
    runVec(mkVec("sw1_id", 0, OP_SW, 6'h00, 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0)));
    runVec(mkVec("sw1_ex", 0, OP_SW, 6'h00, 0, 0, eEX(3'd1, 1, 1, 0, 2'b00)));
    runVec(mkVec("sw1_wait", 0, OP_SW, 6'h00, 0, 0, eMEM(0, 1, 0, 0)));
    runVec(mkVec("sw1_ready", 0, OP_SW, 6'h00, 0, 1, eMEM(0, 1, 1, 0)));
    runVec(mkVec("sw1_next_if", 0, OP_SW, 6'h00, 0, 0, eIF()));

    // reset while waiting in MEM; the later timeout run shows the wait count restarted
    runVec(mkVec("swr_id", 0, OP_SW, 6'h00, 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0)));
    runVec(mkVec("swr_ex", 0, OP_SW, 6'h00, 0, 0, eEX(3'd1, 1, 1, 0, 2'b00)));
    for (int k = 0; k < 5; k++)
      runVec(mkVec($sformatf("swr_wait%0d", k), 0, OP_SW, 6'h00, 0, 0, eMEM(0, 1, 0, 0)));
    runVec(mkVec("swr_rst", 1, OP_SW, 6'h00, 0, 1, '0));
    runVec(mkVec("swr_after_if", 0, OP_SW, 6'h00, 0, 0, eIF()));

    // sw that never gets ready: 15 MEM cycles, error on the last, no WB afterwards
    runVec(mkVec("swt_id", 0, OP_SW, 6'h00, 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0)));
    runVec(mkVec("swt_ex", 0, OP_SW, 6'h00, 0, 0, eEX(3'd1, 1, 1, 0, 2'b00)));
    for (int k = 0; k < 14; k++)
      runVec(mkVec($sformatf("swt_wait%0d", k), 0, OP_SW, 6'h00, 0, 0, eMEM(0, 1, 0, 0)));
    runVec(mkVec("swt_timeout", 0, OP_SW, 6'h00, 0, 0, eMEM(0, 1, 1, 1)));
    runVec(mkVec("swt_next_if", 0, OP_SW, 6'h00, 0, 0, eIF()));

    // lw timeout also returns to IF without WB
    runVec(mkVec("lwt_id", 0, OP_LW, 6'h00, 0, 0, eID(0, 2'b00, 0, 2'b00, 2'b00, 0)));
    runVec(mkVec("lwt_ex", 0, OP_LW, 6'h00, 0, 0, eEX(3'd1, 1, 1, 0, 2'b00)));
    for (int k = 0; k < 14; k++)
      runVec(mkVec($sformatf("lwt_wait%0d", k), 0, OP_LW, 6'h00, 0, 0, eMEM(1, 0, 0, 0)));
    runVec(mkVec("lwt_timeout", 0, OP_LW, 6'h00, 0, 0, eMEM(1, 0, 1, 1)));
    runVec(mkVec("lwt_next_if", 0, OP_LW, 6'h00, 0, 0, eIF()));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
